// File: rtl/cla_sum_accumulator.sv
// Block accumulator behind the 4-bit CLA stage: sums up to BLOCK_LEN adder
// results into a saturating total and hands it off over valid/ready.
module cla_sum_accumulator #(
  parameter int SUM_W     = 5,
  parameter int ACC_W     = 7,
  parameter int BLOCK_LEN = 8,
  localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_acc   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  // One extra bit catches the carry that signals saturation.
  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(in_sum);
  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt_inc == CNT_W'(BLOCK_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        // A lone flush never opens a block, so empty totals are never emitted.
        if (accept) begin
          acc_nx   = ACC_W'(in_sum);
          cnt_nx   = CNT_W'(1);
          state_nx = (BLOCK_LEN == 1 || flush) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (sum_ext[ACC_W]) begin
            acc_nx = '1;
            ovf_nx = 1'b1;
          end else begin
            acc_nx = sum_ext[ACC_W-1:0];
          end
          cnt_nx = cnt_inc;
          if (last) state_nx = HOLD;
        end
        if (flush) state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_sum_accumulator.sv
// Directed bench for cla_sum_accumulator at default parameters.
module tb_cla_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
  logic [4:0] in_sum;
  logic [6:0] out_acc;
  logic [3:0] out_count;
  int         checks = 0;
  int         errors = 0;

  cla_sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] s, input logic f);
    in_valid = 1'b1; in_sum = s; flush = f;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_total(input string tag, input int acc, input int cnt, input int ovf);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_acc"},   out_acc,   acc);
    chk({tag, "_cnt"},   out_count, cnt);
    chk({tag, "_ovf"},   out_ovf,   ovf);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_ready"},   in_ready,  1);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, out_valid, 0);
    chk({tag, "_rst_ready"}, in_ready,  1);
    chk({tag, "_rst_acc"},   out_acc,   0);
    chk({tag, "_rst_cnt"},   out_count, 0);
    chk({tag, "_rst_ovf"},   out_ovf,   0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle with a partially filled block
    send(5'd20, 1'b0);
    send(5'd20, 1'b0);
    chk("pre_rst_acc", out_acc, 40);
    reset_pulse("r0");

    // Flush alone in IDLE is ignored
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("idle_flush_valid", out_valid, 0);
    chk("idle_flush_cnt",   out_count, 0);

    // Partial block closed by flush: 11+19+21+30 = 81
    send(5'b01011, 1'b0);
    send(5'b10011, 1'b0);
    send(5'b10101, 1'b0);
    chk("part_not_yet", out_valid, 0);
    send(5'b11110, 1'b1);
    expect_total("part", 81, 4, 0);
    take("part");

    // Full block of eight 30s saturates (30*5 = 150 > 127)
    for (int i = 0; i < 7; i++) send(5'd30, 1'b0);
    chk("full_not_yet", out_valid, 0);
    send(5'd30, 1'b0);
    expect_total("full", 127, 8, 1);
    take("full");

    // Exact boundary: 31*4 + 3 = 127 stays unsaturated
    for (int i = 0; i < 4; i++) send(5'd31, 1'b0);
    send(5'd3, 1'b1);
    expect_total("edge127", 127, 5, 0);
    take("edge127");

    // One past: 31*4 + 4 = 128 saturates
    for (int i = 0; i < 4; i++) send(5'd31, 1'b0);
    send(5'd4, 1'b1);
    expect_total("edge128", 127, 5, 1);
    take("edge128");

    // Seven 31s with flush: overflow early, stays saturated
    for (int i = 0; i < 6; i++) send(5'd31, 1'b0);
    send(5'd31, 1'b1);
    expect_total("sat7", 127, 7, 1);
    take("sat7");

    // Backpressure: HOLD with in_valid asserted for 5 cycles
    send(5'd5, 1'b1);
    expect_total("bp_a", 5, 1, 0);
    in_valid = 1'b1; in_sum = 5'd9; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready,  0);
      chk("bp_hold_acc",   out_acc,   5);
      chk("bp_hold_cnt",   out_count, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_exit_valid", out_valid, 0);
    chk("bp_exit_ready", in_ready,  1);
    chk("bp_exit_acc",   out_acc,   0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    expect_total("bp_b", 9, 1, 0);
    take("bp_b");

    // Reset mid-block discards the partial sum
    send(5'd10, 1'b0);
    send(5'd10, 1'b0);
    send(5'd10, 1'b0);
    reset_pulse("r1");
    chk("r1_no_valid", out_valid, 0);
    send(5'd7, 1'b0);
    send(5'd8, 1'b1);
    expect_total("post_rst", 15, 2, 0);
    take("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
